// File: rtl/mix_io_pkg.sv
// Shared MIX I/O definitions: character/word geometry and the UART receiver state encoding.
package mix_io_pkg;
  localparam int MIX_CHAR_W     = 6;
  localparam int CHARS_PER_WORD = 5;
  localparam int MIX_WORD_W     = 30;
  localparam int MIX_ADDR_W     = 12;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver: 2-flop rx synchroniser, mid-bit sampling FSM, byte and frame-error strobes.
module uart_rx_byte
  import mix_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [7:0]  rx_byte,
  output logic        byte_strobe,
  output logic        frame_err,
  output uart_state_t state_dbg
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta;
  logic             rx_s;
  uart_state_t      state;
  uart_state_t      state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             sample_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= UART_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      UART_IDLE:  if (!rx_s) state_next = UART_START;
      UART_START: if (sample_tick) state_next = rx_s ? UART_IDLE : UART_DATA;
      UART_DATA:  if (sample_tick && bit_idx == 3'd7) state_next = UART_STOP;
      UART_STOP:  if (sample_tick) state_next = UART_IDLE;
      default:    state_next = UART_IDLE;
    endcase
  end

  // The start bit is sampled half a bit in, so every later sample lands mid-bit.
  always_comb begin
    sample_tick = 1'b0;
    byte_strobe = 1'b0;
    frame_err   = 1'b0;
    unique case (state)
      UART_START: sample_tick = (cnt == HALF_LAST);
      UART_DATA:  sample_tick = (cnt == FULL_LAST);
      UART_STOP: begin
        sample_tick = (cnt == FULL_LAST);
        byte_strobe = sample_tick && rx_s;
        frame_err   = sample_tick && !rx_s;
      end
      default: sample_tick = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (state != state_next || sample_tick || state == UART_IDLE) cnt <= '0;
      else                                                          cnt <= cnt + 1'b1;
      if (state == UART_START) bit_idx <= '0;
      if (state == UART_DATA && sample_tick) begin
        shift   <= {rx_s, shift[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  assign rx_byte   = shift;
  assign state_dbg = state;
endmodule

// File: rtl/mix_out_receiver.sv
// MIX OUT receive end: packs UART bytes carrying 6-bit MIX chars into 30-bit words and
// hands each word to a consumer through a one-entry holding register.
module mix_out_receiver
  import mix_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int BLOCK_WORDS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic                  sync,
  output logic [MIX_WORD_W-1:0] word,
  output logic [MIX_ADDR_W-1:0] word_index,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  block_done,
  output logic                  frame_err,
  output logic                  char_err,
  output logic                  overrun
);
  // Handshake: a word transfers on any rising clk edge where word_valid && word_ready;
  // word_valid stays high and word/word_index stay stable until that transfer happens.

  localparam logic [2:0]            LAST_CHAR = 3'(CHARS_PER_WORD - 1);
  localparam logic [MIX_ADDR_W-1:0] LAST_WORD = MIX_ADDR_W'(BLOCK_WORDS - 1);

  logic [7:0]            rx_byte;
  logic                  byte_strobe;
  logic                  uart_frame_err;
  uart_state_t           unused_uart_state;  // exported for probing only
  logic [2:0]            char_idx;
  logic [MIX_WORD_W-1:0] shift_reg;
  logic [MIX_WORD_W-1:0] next_shift;
  logic [MIX_ADDR_W-1:0] word_count;
  logic                  char_ok;
  logic                  word_done;
  logic                  can_load;
  logic                  accept;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_strobe(byte_strobe),
    .frame_err  (uart_frame_err),
    .state_dbg  (unused_uart_state)
  );

  always_comb begin
    char_ok    = (rx_byte[7:6] == 2'b00);
    next_shift = {shift_reg[MIX_WORD_W-MIX_CHAR_W-1:0], rx_byte[MIX_CHAR_W-1:0]};
    // sync outranks a completing word: the word is discarded, not reported as overrun.
    word_done  = byte_strobe && char_ok && (char_idx == LAST_CHAR) && !sync;
    accept     = word_valid && word_ready;
    can_load   = !word_valid || word_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      char_idx   <= '0;
      shift_reg  <= '0;
      word_count <= '0;
      word       <= '0;
      word_index <= '0;
      word_valid <= 1'b0;
      block_done <= 1'b0;
      frame_err  <= 1'b0;
      char_err   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      block_done <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= uart_frame_err;
      char_err   <= byte_strobe && !char_ok;

      if (sync) begin
        char_idx   <= '0;
        shift_reg  <= '0;
        word_count <= '0;
      end else if (byte_strobe && char_ok) begin
        shift_reg <= next_shift;
        char_idx  <= (char_idx == LAST_CHAR) ? 3'd0 : char_idx + 3'd1;
      end

      if (word_done) begin
        if (can_load) begin
          word       <= next_shift;
          word_index <= word_count;
          word_valid <= 1'b1;
          block_done <= (word_count == LAST_WORD);
          word_count <= (word_count == LAST_WORD) ? '0 : word_count + 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        word_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mix_out_receiver.sv
// Randomised bench for mix_out_receiver: a char-queue reference model predicts words, indices and pulses.
module tb_mix_out_receiver;
  import mix_io_pkg::*;

  localparam int CPB = 8;
  localparam int BW  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        sync = 1'b0;
  logic        word_ready = 1'b0;
  logic [29:0] word;
  logic [11:0] word_index;
  logic        word_valid;
  logic        block_done;
  logic        frame_err;
  logic        char_err;
  logic        overrun;

  always #5 clk = ~clk;

  mix_out_receiver #(
    .CLKS_PER_BIT(CPB),
    .BLOCK_WORDS (BW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .sync      (sync),
    .word      (word),
    .word_index(word_index),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .block_done(block_done),
    .frame_err (frame_err),
    .char_err  (char_err),
    .overrun   (overrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state
  int          chars_q[$];
  int          model_idx = 0;
  bit          model_full = 0;
  logic [29:0] exp_q[$];
  logic [11:0] exp_idx_q[$];
  int          bd_exp = 0, ovr_exp = 0, cerr_exp = 0, ferr_exp = 0;
  int          bd_seen = 0, ovr_seen = 0, cerr_seen = 0, ferr_seen = 0;
  logic [29:0] last_word = '0;
  logic [11:0] last_idx = '0;

  function automatic void model_byte(input logic [7:0] b, input logic stop_bit);
    int w;
    if (!stop_bit) ferr_exp++;
    else if (b > 8'd63) cerr_exp++;
    else begin
      chars_q.push_back(int'(b));
      if (chars_q.size() == 5) begin
        w = 0;
        foreach (chars_q[i]) w = w * 64 + chars_q[i];
        chars_q.delete();
        if (word_ready || !model_full) begin
          exp_q.push_back(30'(w));
          exp_idx_q.push_back(12'(model_idx));
          if (model_idx == BW - 1) bd_exp++;
          model_idx = (model_idx + 1) % BW;
          if (!word_ready) model_full = 1;
        end else begin
          ovr_exp++;
        end
      end
    end
  endfunction

  // Monitor: counts pulses and scores every accepted word against the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (block_done) begin
        bd_seen++;
        check("bd_index", 32'(word_index), BW - 1);
        check("bd_valid", 32'(word_valid), 1);
      end
      if (overrun)   ovr_seen++;
      if (char_err)  cerr_seen++;
      if (frame_err) ferr_seen++;
      if (word_valid && word_ready) begin
        check("word_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check("word_value", 32'(word), 32'(exp_q.pop_front()));
          check("word_index", 32'(word_index), 32'(exp_idx_q.pop_front()));
          last_word = word;
          last_idx  = word_index;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic r);
    word_ready = r;
    if (r) model_full = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    model_byte(b, stop_bit);
    tick(CPB);
    rx = 1'b1;
    tick(4 + int'($urandom_range(0, 3)));
  endtask

  task automatic send_word(input logic [29:0] w);
    for (int i = 4; i >= 0; i--) send_byte({2'b00, w[i*6 +: 6]}, 1'b1);
  endtask

  task automatic do_sync();
    sync = 1'b1;
    tick(1);
    sync = 1'b0;
    chars_q.delete();
    model_idx = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sync  = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(1);
    check("rst_word", 32'(word), 0);
    check("rst_index", 32'(word_index), 0);
    check("rst_valid", 32'(word_valid), 0);
    check("rst_pulses", {28'd0, block_done, frame_err, char_err, overrun}, 0);
    chars_q.delete();
    exp_q.delete();
    exp_idx_q.delete();
    model_idx  = 0;
    model_full = 0;
    reset = 1'b0;
    tick(3);
  endtask

  task automatic end_scenario(input string tag);
    set_ready(1'b1);
    tick(30);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_block_done"}, bd_seen, bd_exp);
    check({tag, "_overrun"}, ovr_seen, ovr_exp);
    check({tag, "_char_err"}, cerr_seen, cerr_exp);
    check({tag, "_frame_err"}, ferr_seen, ferr_exp);
  endtask

  initial begin
    int r;
    do_reset();

    // Basic word: chars 1..5 -> 000001_000010_000011_000100_000101
    set_ready(1'b1);
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    end_scenario("basic");
    check("basic_const", 32'(last_word), 32'h0108_3105);
    check("basic_idx", 32'(last_idx), 0);

    // Five words: indices 0..3 then wrap to 0, block_done only at index 3
    do_reset();
    set_ready(1'b1);
    for (int k = 0; k < 5; k++) send_word(30'($urandom));
    end_scenario("block");
    check("block_wrap_idx", 32'(last_idx), 0);

    // Holding register busy: second word dropped, third gets index 1
    do_reset();
    set_ready(1'b0);
    send_word(30'($urandom));
    send_word(30'($urandom));
    tick(4);
    check("ovr_held_valid", 32'(word_valid), 1);
    check("ovr_held_word", 32'(word), 32'(exp_q[0]));
    set_ready(1'b1);
    tick(4);
    send_word(30'($urandom));
    end_scenario("overrun");
    check("ovr_third_idx", 32'(last_idx), 1);

    // Bad char discarded, then five good chars make one word
    do_reset();
    set_ready(1'b1);
    send_byte(8'h45, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 63)), 1'b1);
    end_scenario("char_err");

    // Frame error and rx glitch do not advance the char position
    do_reset();
    set_ready(1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(20);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 63)), 1'b1);
    end_scenario("frame");

    // sync discards a partial word and restarts the block
    do_reset();
    set_ready(1'b1);
    send_word(30'($urandom));
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 63)), 1'b1);
    do_sync();
    send_word(30'($urandom));
    end_scenario("sync");
    check("sync_idx", 32'(last_idx), 0);

    // Reset in the middle of a word and of a byte
    do_reset();
    set_ready(1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 63)), 1'b1);
    rx = 1'b0;
    tick(CPB * 3);
    do_reset();
    set_ready(1'b1);
    send_word(30'($urandom));
    end_scenario("mid_reset");
    check("mid_reset_idx", 32'(last_idx), 0);

    // Random mix of good chars, bad chars, framing errors and syncs
    do_reset();
    set_ready(1'b1);
    for (int k = 0; k < 60; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10)      send_byte(8'($urandom_range(64, 255)), 1'b1);
      else if (r < 18) send_byte(8'($urandom), 1'b0);
      else if (r < 24) do_sync();
      else             send_byte(8'($urandom_range(0, 63)), 1'b1);
    end
    end_scenario("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
